// File: rtl/im_arbiter.sv
// Fixed-priority two-port arbiter in front of the single-read-port instruction memory.
// Fetch wins by default; a saturating starvation counter guarantees the debug port a slot.
module im_arbiter #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_data,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_data,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [DATA_W-1:0] im_data
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnF    = 2'd1,
    OwnD    = 2'd2
  } own_e;

  own_e              own1_q, own1_d;
  logic [3:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] sel_addr;

  always_comb begin
    d_gnt = !rst && d_req && (!f_req || (starve_q == StarveMax));
    f_gnt = !rst && f_req && !d_gnt;
  end

  always_comb begin
    starve_d = starve_q;
    if (d_gnt || !d_req) begin
      starve_d = 4'd0;
    end else if (f_gnt && (starve_q != StarveMax)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    own1_d = OwnNone;
    if (f_gnt) begin
      own1_d = OwnF;
    end else if (d_gnt) begin
      own1_d = OwnD;
    end
  end

  assign sel_addr = d_gnt ? d_addr : f_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 4'd0;
      own1_q   <= OwnNone;
      im_addr  <= '0;
    end else begin
      starve_q <= starve_d;
      own1_q   <= own1_d;
      // Misaligned requests are silently word-aligned.
      if (f_gnt || d_gnt) begin
        im_addr <= sel_addr & ~ADDR_W'(3);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_valid <= 1'b0;
      d_valid <= 1'b0;
      f_data  <= '0;
      d_data  <= '0;
    end else begin
      f_valid <= (own1_q == OwnF);
      d_valid <= (own1_q == OwnD);
      if (own1_q == OwnF) begin
        f_data <= im_data;
      end
      if (own1_q == OwnD) begin
        d_data <= im_data;
      end
    end
  end

endmodule

// File: doc/im_arbiter.md
# im_arbiter

Two-port arbiter in front of the single-read-port instruction memory. It lets the CPU fetch stage and a debug/display reader share that memory. Fetch has priority; a bounded-starvation counter guarantees the debug port a slot. Both return paths are fully registered with a fixed latency. The block sits between the PC/fetch logic and the instruction memory, and drives the memory's byte address.

## Interface
- ADDR_W, 12: byte-address width presented to the instruction memory.
- DATA_W, 32: instruction word width.
- STARVE_MAX, 4: consecutive denied debug-request cycles after which debug wins one cycle (legal 1..15).

- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- f_req  in  1  fetch request.
- f_addr  in  ADDR_W  fetch byte address.
- f_gnt  out  1  fetch request accepted this cycle (combinational).
- f_valid  out  1  fetch read data valid (registered, one-cycle pulse per grant).
- f_data  out  DATA_W  fetch read data.
- d_req  in  1  debug request.
- d_addr  in  ADDR_W  debug byte address.
- d_gnt  out  1  debug request accepted this cycle (combinational).
- d_valid  out  1  debug read data valid (registered).
- d_data  out  DATA_W  debug read data.
- im_addr  out  ADDR_W  registered address to the instruction memory.
- im_data  in  DATA_W  combinational read data from the instruction memory.

## Operation
- Requester protocol:
  - A requester holds x_req high and x_addr stable until it sees x_gnt high in the same cycle.
  - A grant consumes the request that cycle.
  - Dropping x_req before the grant withdraws the request; this is legal.
- Grant rule, evaluated each cycle:
  - d_gnt = !rst && d_req && (!f_req || starve == STARVE_MAX).
  - f_gnt = !rst && f_req && !d_gnt.
  - At most one grant per cycle.
- Starvation counter `starve`, width 4:
  - On d_gnt, or when d_req is low: clears to 0.
  - Else, if d_req && f_gnt: increments, saturating at STARVE_MAX.
- Address path: on any grant, im_addr <= granted address with bits [1:0] forced to 0 (word aligned). With no grant, im_addr holds its value.
- Owner pipeline, stage 1: own1 ∈ {NONE, F, D} is registered with the grant.
- Owner pipeline, stage 2: on the next edge, when own1 = F, f_data <= im_data and f_valid <= 1. When own1 = D, the same applies to d_data and d_valid.
- The non-selected valid output is 0. Data registers hold their value while not written.
- Throughput: one grant per cycle, back-to-back, with no bubbles.
- Owner state changes with each grant; there is no other FSM.

## Timing
- Grant appears in the request cycle N.
- im_addr updates at the end of cycle N.
- x_valid/x_data are visible during cycle N+2, giving a fixed latency of 2.
- Responses return in grant order.
- Reset values:
  - im_addr = 0.
  - own1 = NONE.
  - f_valid = d_valid = 0.
  - f_data = d_data = 0.
  - starve = 0.
  - f_gnt = d_gnt = 0 while rst is high.
- Reset mid-operation: all in-flight grants are discarded and no valid pulse follows. The first grant after rst deasserts yields valid 2 cycles later.
- Simultaneous requests: fetch wins unless starve == STARVE_MAX.
- With both requests held continuously, the grant pattern is F×STARVE_MAX followed by D×1, repeating.
- With no f_req, debug is granted every cycle.
- Misaligned addresses are silently aligned; no error output.
- The address wraps naturally at 2^ADDR_W.

## Test plan
- Fetch only: f_req held, f_addr = 0x000, 0x004, 0x008 on consecutive grants.
  - f_gnt is high for 3 cycles.
  - f_valid is high in cycles 2–4 with im_data for words 0, 1, 2.
  - d_valid stays 0.
- Debug only: d_req with d_addr = 0x016.
  - d_gnt is high in cycle 0 and im_addr = 0x014 after cycle 0.
  - d_valid is high in cycle 2 carrying word 5.
- Contention: f_req and d_req both held for 10 cycles with STARVE_MAX = 4.
  - Grants are F, F, F, F, D, F, F, F, F, D.
  - Valids follow the same order, delayed by 2 cycles.
- Withdrawal: d_req high for 2 cycles under continuous f_req, then low for 1 cycle, then high again.
  - starve returns to 0.
  - Debug is not granted until 4 further denied cycles have elapsed.
- Reset mid-flight: grant fetch at cycle 0 and assert rst in cycle 1.
  - No f_valid pulse occurs.
  - All outputs and im_addr are 0 after the edge.
  - A new grant after reset returns in 2 cycles.
- Back-to-back alternating ownership: cycle 0 fetch only, then cycle 1 debug only, then cycle 2 fetch only.
  - f_valid is high in cycles 2 and 4; d_valid is high in cycle 3.
  - Each valid carries the correct word, and the other valid output is low in each of those cycles.
